// File: rtl/dwc_downconv_wr_cmd_split.sv
// ---------------------------------------------------------------------------------------------
// dwc_downconv_wr_cmd_split
//
// Write-command splitter for the down-converting data-width converter. One pre-calculated
// master write command is accepted and then emitted as one or more slave bursts of at most
// max_length_pre beats. Each slave burst first gets one entry in the downstream command FIFO,
// which tells the write-data path how to slice the master beats. The matching slave address
// command follows.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   MASTER_AVALID/AREADY  master command handshake (AREADY high only while idle)
//   MASTER_AADDR_mux, MASTER_AID, MASTER_ABURST
//                       start address, ID and burst type of the master command
//   ASIZE_pre           slave transfer size (log2 bytes)
//   tot_len_pre         total number of slave beats, 1..4096
//   max_length_pre      maximum beats per slave burst, 1..256
//   sizeMax_pre         split count per master beat, minus one
//   sizeCnt_pre         split start index for the first master beat
//   SLAVE_AVALID/AREADY slave address handshake
//   SLAVE_AADDR, SLAVE_ALEN, SLAVE_ASIZE, SLAVE_ABURST, SLAVE_AID
//                       slave address payload, all registered
//   cmd_fifo_full       downstream command FIFO cannot take an entry
//   cmd_fifo_we         single-cycle FIFO write strobe
//   cmd_fifo_wdata      {last, slave_len[7:0], sizeCnt[5:0], sizeMax[5:0]}
// ---------------------------------------------------------------------------------------------

module dwc_downconv_wr_cmd_split #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  MASTER_AVALID,
    output logic                  MASTER_AREADY,
    input  logic [ADDR_WIDTH-1:0] MASTER_AADDR_mux,
    input  logic [ID_WIDTH-1:0]   MASTER_AID,
    input  logic [1:0]            MASTER_ABURST,
    input  logic [2:0]            ASIZE_pre,
    input  logic [12:0]           tot_len_pre,
    input  logic [8:0]            max_length_pre,
    input  logic [5:0]            sizeMax_pre,
    input  logic [5:0]            sizeCnt_pre,

    output logic                  SLAVE_AVALID,
    input  logic                  SLAVE_AREADY,
    output logic [ADDR_WIDTH-1:0] SLAVE_AADDR,
    output logic [7:0]            SLAVE_ALEN,
    output logic [2:0]            SLAVE_ASIZE,
    output logic [1:0]            SLAVE_ABURST,
    output logic [ID_WIDTH-1:0]   SLAVE_AID,

    input  logic                  cmd_fifo_full,
    output logic                  cmd_fifo_we,
    output logic [20:0]           cmd_fifo_wdata
);

    localparam logic [1:0] BurstIncr = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        PUSH,
        ADDR
    } state_t;

    state_t          state;
    logic [12:0]     remaining;     // slave beats not yet covered by an address handshake
    logic [8:0]      max_len;
    logic [5:0]      size_max;
    logic [5:0]      cur_size_cnt;  // only the first burst starts mid master beat
    logic [8:0]      burst_beats;   // beats in the burst currently being issued

    logic [8:0]            beats_now;
    logic [7:0]            alen_now;
    logic                  last_now;
    logic [12:0]           remaining_after;
    logic [ADDR_WIDTH-1:0] addr_step;

    // Master side is ready purely as a function of the state.
    assign MASTER_AREADY = (state == IDLE);

    // Burst size for the next push: min(remaining, max_len) on 13 bits.
    always_comb begin
        beats_now = max_len;
        if (remaining < {4'b0000, max_len}) begin
            beats_now = remaining[8:0];
        end
    end

    // A 256-beat burst wraps to ALEN 8'hFF through the 8-bit cast.
    assign alen_now        = 8'(beats_now - 9'd1);
    assign last_now        = (remaining == {4'b0000, beats_now});
    assign remaining_after = remaining - {4'b0000, burst_beats};
    assign addr_step       = ADDR_WIDTH'({4'b0000, burst_beats}) << SLAVE_ASIZE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            remaining      <= '0;
            max_len        <= '0;
            size_max       <= '0;
            cur_size_cnt   <= '0;
            burst_beats    <= '0;
            SLAVE_AVALID   <= 1'b0;
            SLAVE_AADDR    <= '0;
            SLAVE_ALEN     <= '0;
            SLAVE_ASIZE    <= '0;
            SLAVE_ABURST   <= '0;
            SLAVE_AID      <= '0;
            cmd_fifo_we    <= 1'b0;
            cmd_fifo_wdata <= '0;
        end else begin
            cmd_fifo_we <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (MASTER_AVALID) begin
                        SLAVE_AADDR  <= MASTER_AADDR_mux;
                        SLAVE_AID    <= MASTER_AID;
                        SLAVE_ABURST <= MASTER_ABURST;
                        SLAVE_ASIZE  <= ASIZE_pre;
                        remaining    <= tot_len_pre;
                        max_len      <= max_length_pre;
                        size_max     <= sizeMax_pre;
                        cur_size_cnt <= sizeCnt_pre;
                        state        <= PUSH;
                    end
                end

                PUSH: begin
                    // The FIFO entry is written before the address goes out so the data path
                    // always knows how to slice the burst by the time it can be accepted.
                    if (!cmd_fifo_full) begin
                        cmd_fifo_we    <= 1'b1;
                        cmd_fifo_wdata <= {last_now, alen_now, cur_size_cnt, size_max};
                        SLAVE_ALEN     <= alen_now;
                        burst_beats    <= beats_now;
                        state          <= ADDR;
                    end
                end

                ADDR: begin
                    // First ADDR cycle carries the FIFO write; AVALID rises one cycle later
                    // and then holds until the slave takes it.
                    if (!SLAVE_AVALID) begin
                        SLAVE_AVALID <= 1'b1;
                    end else if (SLAVE_AREADY) begin
                        SLAVE_AVALID <= 1'b0;
                        remaining    <= remaining_after;
                        cur_size_cnt <= '0;
                        if (SLAVE_ABURST == BurstIncr) begin
                            SLAVE_AADDR <= SLAVE_AADDR + addr_step;
                        end
                        state <= (remaining_after == 13'd0) ? IDLE : PUSH;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dwc_downconv_wr_cmd_split.md
DWC_DOWNCONV_WR_CMD_SPLIT -- requirements
Module: caxi4interconnect_DWC_DownConv_wrCmdSplit

Parameters
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: address width.
REQ-002 SHALL have parameter ID_WIDTH, default 32: ID width.

Interface
REQ-003 clk  in  1  clock, all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 MASTER_AVALID  in  1  pre-calculated command valid.
REQ-006 MASTER_AREADY  out  1  command accepted.
REQ-007 MASTER_AADDR_mux  in  ADDR_WIDTH  start address.
REQ-008 MASTER_AID  in  ID_WIDTH  transaction ID.
REQ-009 MASTER_ABURST  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP.
REQ-010 ASIZE_pre  in  3  slave transfer size.
REQ-011 tot_len_pre  in  13  total slave beats, 1..4096.
REQ-012 max_length_pre  in  9  max beats per slave burst, 1..256.
REQ-013 sizeMax_pre  in  6  per-master-beat split count minus 1.
REQ-014 sizeCnt_pre  in  6  first-beat split start index.
REQ-015 SLAVE_AVALID  out  1; SLAVE_AREADY  in  1: slave address handshake.
REQ-016 SLAVE_AADDR  out  ADDR_WIDTH; SLAVE_ALEN  out  8; SLAVE_ASIZE  out  3; SLAVE_ABURST  out  2; SLAVE_AID  out  ID_WIDTH.
REQ-017 cmd_fifo_full  in  1  downstream command FIFO full.
REQ-018 cmd_fifo_we  out  1  one-cycle FIFO write strobe.
REQ-019 cmd_fifo_wdata  out  21  {last[20], slave_len[19:12], sizeCnt[11:6], sizeMax[5:0]}.

Function
REQ-020 FSM states SHALL be IDLE, PUSH, ADDR.
REQ-021 MASTER_AREADY SHALL equal (state==IDLE); it is combinational from state only.
REQ-022 IDLE: on MASTER_AVALID&MASTER_AREADY, latch all inputs, set remaining=tot_len_pre, cur_sizeCnt=sizeCnt_pre, go PUSH.
REQ-023 PUSH: burst beats B=min(remaining,max_length); when cmd_fifo_full=0, pulse cmd_fifo_we for 1 cycle, register SLAVE_ALEN=B-1, drive wdata {remaining==B, B-1, cur_sizeCnt, sizeMax}, go ADDR; when full, hold in PUSH with we=0.
REQ-024 ADDR: SLAVE_AVALID=1 with stable payload until SLAVE_AREADY=1; AVALID SHALL NOT deassert before handshake.
REQ-025 On ADDR handshake: remaining -= B; INCR: address += B<<ASIZE (ADDR_WIDTH modulo); FIXED/WRAP: address unchanged; cur_sizeCnt=0; go IDLE if remaining becomes 0, else PUSH.
REQ-026 SLAVE_ASIZE, SLAVE_ABURST, SLAVE_AID SHALL equal latched values for all split bursts.
REQ-027 Latency: accept at cycle N -> cmd_fifo_we at N+1 (FIFO not full) -> SLAVE_AVALID from N+2.
REQ-028 FIFO write precedes its address command; exactly one FIFO entry per slave burst; last=1 only on final burst.
REQ-029 remaining is 13-bit; min compare on 13 bits, max_length zero-extended; B=256 yields SLAVE_ALEN=8'hFF.
REQ-030 cmd_fifo_full toggling during ADDR SHALL have no effect; SLAVE_AREADY outside ADDR SHALL be ignored.
REQ-031 New master command SHALL not be accepted until final burst handshake completes (returns IDLE the next cycle).

Reset
REQ-032 On rst=0: state IDLE, MASTER_AREADY=1 after release, SLAVE_AVALID=0, cmd_fifo_we=0, SLAVE_AADDR/ALEN/ASIZE/ABURST/AID=0, cmd_fifo_wdata=0, remaining=0.
REQ-033 Reset mid-burst SHALL abort immediately; no pending bursts resume after release.

Verification
REQ-034 INCR, addr 0x1000, ASIZE 2, tot_len 4, max 256, sizeCnt 1 -> one FIFO entry {1,3,1,sizeMax}, SLAVE_ALEN=3, addr 0x1000.
REQ-035 INCR, addr 0x0, ASIZE 2, tot_len 512, max 256 -> two bursts ALEN 0xFF at 0x000 and 0x400, last=0 then 1, sizeCnt second=0.
REQ-036 FIXED, addr 0x20, tot_len 300, max 256 -> bursts ALEN 0xFF and 0x2B, both addr 0x20, ABURST 00.
REQ-037 cmd_fifo_full=1 for 5 cycles at PUSH -> no we, no AVALID; we one cycle after full clears, AVALID the next.
REQ-038 SLAVE_AREADY held 0 for 10 cycles -> AVALID and payload stable, MASTER_AREADY=0, new AVALID ignored.
REQ-039 rst asserted during ADDR of 2-burst INCR -> all outputs 0 immediately, IDLE with MASTER_AREADY=1 after release.
